// File: rtl/struct_array_sequencer.sv
// Accepts a packed word of 7-bit {a, b[3:0], c[1:0]} records and streams
// entries 0..count-1 out one per valid/ready beat, pulsing done after the last.
module struct_array_sequencer #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ENTRIES*7-1:0]   in_data,
    input  logic [CNT_W-1:0]       in_count,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_a,
    output logic [3:0]             out_b,
    output logic [1:0]             out_c,
    output logic                   out_last,
    output logic                   done
);

    localparam int unsigned ENTRY_W = 7;
    localparam int unsigned DATA_W  = ENTRIES * ENTRY_W;

    typedef struct packed {
        logic       a;
        logic [3:0] b;
        logic [1:0] c;
    } rec_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;

    logic [CNT_W-1:0]   w_cnt_eff;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_xfer;
    logic               w_last;
    rec_t               w_entries [ENTRIES];
    rec_t               w_rec;

    // Counts larger than the word are clamped to the number of records held.
    assign w_cnt_eff = (in_count > CNT_W'(ENTRIES)) ? CNT_W'(ENTRIES) : in_count;
    assign w_last    = (CNT_W'(r_idx) == (r_count - CNT_W'(1)));
    assign w_accept  = in_valid && w_in_ready;
    assign w_xfer    = w_out_valid && out_ready;

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            w_entries[i] = r_data[i*ENTRY_W +: ENTRY_W];
        end
    end

    assign w_rec = w_entries[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = !flush;
                if (in_valid && w_in_ready && (w_cnt_eff != '0)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_out_valid = 1'b1;
                if (flush || (out_ready && w_last)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Word capture, index stepping and done pulse; a flush suppresses both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_xfer && w_last && !flush;
            if (w_accept) begin
                r_data  <= in_data;
                r_count <= w_cnt_eff;
                r_idx   <= '0;
            end else if (w_xfer && !w_last && !flush) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready && !rst;
    assign out_valid = w_out_valid;
    assign out_index = r_idx;
    assign out_a     = w_rec.a;
    assign out_b     = w_rec.b;
    assign out_c     = w_rec.c;
    assign out_last  = w_out_valid && w_last;
    assign done      = r_done;

endmodule

// File: tb/tb_struct_array_sequencer.sv
// Bench for struct_array_sequencer: randomized words and backpressure checked
// against a per-entry arithmetic model of the record stream.
module tb_struct_array_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] in_data;
    logic [3:0]  in_count;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_index;
    logic        out_a;
    logic [3:0]  out_b;
    logic [1:0]  out_c;
    logic        out_last;
    logic        done;

    struct_array_sequencer #(.ENTRIES(8), .IDX_W(3), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_last  (out_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [55:0] VEC = 56'h7B6EF9F728B9A8;

    int errors = 0;
    int checks = 0;

    int         got_idx  [$];
    logic [6:0] got_rec  [$];
    logic       got_last [$];
    int         got_cyc  [$];
    int         done_cnt;
    int         done_cyc;
    int         first_valid_cyc;
    int         valid_cycles;
    int         stall_viol;

    function automatic logic [6:0] model_rec(input logic [55:0] d, input int i);
        logic [55:0] s;
        s = d >> (7 * i);
        return s[6:0];
    endfunction

    function automatic int model_beats(input int c);
        return (c > 8) ? 8 : c;
    endfunction

    // Offers one word, then records every transferred beat, stalls and done pulses.
    task automatic run_word(input logic [55:0] d, input logic [3:0] c,
                            input int rdy_pct, input int max_cyc);
        logic [10:0] snap;
        logic        stalled;
        got_idx.delete(); got_rec.delete(); got_last.delete(); got_cyc.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; valid_cycles = 0;
        stall_viol = 0; stalled = 1'b0; snap = '0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_count = c; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (cyc != 0) @(negedge clk);
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stalled && ({out_index, out_a, out_b, out_c, out_last} !== snap)) stall_viol++;
                if (out_ready) begin
                    got_idx.push_back(int'(out_index));
                    got_rec.push_back({out_a, out_b, out_c});
                    got_last.push_back(out_last);
                    got_cyc.push_back(cyc);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    snap = {out_index, out_a, out_b, out_c, out_last};
                end
            end else begin
                stalled = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if ({out_valid, done, out_last} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got valid=%b done=%b last=%b exp=000", out_valid, done, out_last);
        end
        checks++;
        if ({out_index, out_a, out_b, out_c} !== 10'd0) begin
            errors++; $display("FAIL reset_fields got idx=%0d a=%b b=%b c=%b exp=0", out_index, out_a, out_b, out_c);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_full;
        logic [6:0] exp_tab [8];
        exp_tab = '{7'b0101000, 7'b1110011, 7'b0100010, 7'b0111001,
                    7'b0011111, 7'b1011111, 7'b1011011, 7'b0111101};
        run_word(VEC, 4'd8, 100, 20);
        checks++;
        if (got_idx.size() != 8) begin errors++; $display("FAIL full_nbeats got=%0d exp=8", got_idx.size()); end
        for (int i = 0; i < 8 && i < got_idx.size(); i++) begin
            checks++;
            if (got_idx[i] !== i || got_rec[i] !== exp_tab[i] || got_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL full_beat%0d got idx=%0d rec=%b last=%b exp idx=%0d rec=%b last=%b",
                         i, got_idx[i], got_rec[i], got_last[i], i, exp_tab[i], (i == 7));
            end
        end
        checks++;
        if (first_valid_cyc !== 0) begin errors++; $display("FAIL full_latency got=%0d exp=0", first_valid_cyc); end
        checks++;
        if (valid_cycles !== 8) begin errors++; $display("FAIL full_run_cycles got=%0d exp=8", valid_cycles); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", done_cnt); end
        if (got_cyc.size() == 8) begin
            checks++;
            if (done_cyc !== got_cyc[7] + 1) begin
                errors++; $display("FAIL full_done_timing got=%0d exp=%0d", done_cyc, got_cyc[7] + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [55:0] d;
        for (int w = 0; w < 3; w++) begin
            d = (w == 0) ? VEC : 56'({$urandom(), $urandom()});
            run_word(d, 4'd8, 45, 300);
            checks++;
            if (got_idx.size() != 8) begin errors++; $display("FAIL bp%0d_nbeats got=%0d exp=8", w, got_idx.size()); end
            for (int i = 0; i < 8 && i < got_idx.size(); i++) begin
                checks++;
                if (got_idx[i] !== i || got_rec[i] !== model_rec(d, i) || got_last[i] !== (i == 7)) begin
                    errors++;
                    $display("FAIL bp%0d_beat%0d got idx=%0d rec=%b last=%b exp idx=%0d rec=%b",
                             w, i, got_idx[i], got_rec[i], got_last[i], i, model_rec(d, i));
                end
            end
            checks++;
            if (stall_viol !== 0) begin errors++; $display("FAIL bp%0d_stable got=%0d changes exp=0", w, stall_viol); end
            checks++;
            if (done_cnt !== 1) begin errors++; $display("FAIL bp%0d_done got=%0d exp=1", w, done_cnt); end
        end
    endtask

    task automatic test_counts;
        logic [55:0] d;
        logic [3:0]  c;
        int          n;
        for (int t = 0; t < 8; t++) begin
            case (t)
                0: begin d = VEC; c = 4'd0; end
                1: begin d = VEC; c = 4'd3; end
                2: begin d = VEC; c = 4'd12; end
                default: begin d = 56'({$urandom(), $urandom()}); c = 4'($urandom_range(15)); end
            endcase
            n = model_beats(int'(c));
            run_word(d, c, (t < 3) ? 100 : 70, (n == 0) ? 6 : 100);
            checks++;
            if (got_idx.size() != n) begin
                errors++; $display("FAIL cnt%0d_nbeats count=%0d got=%0d exp=%0d", t, c, got_idx.size(), n);
            end
            for (int i = 0; i < n && i < got_idx.size(); i++) begin
                checks++;
                if (got_idx[i] !== i || got_rec[i] !== model_rec(d, i) || got_last[i] !== (i == n - 1)) begin
                    errors++;
                    $display("FAIL cnt%0d_beat%0d got idx=%0d rec=%b last=%b exp idx=%0d rec=%b last=%b",
                             t, i, got_idx[i], got_rec[i], got_last[i], i, model_rec(d, i), (i == n - 1));
                end
            end
            checks++;
            if (done_cnt !== ((n > 0) ? 1 : 0)) begin
                errors++; $display("FAIL cnt%0d_done got=%0d exp=%0d", t, done_cnt, (n > 0) ? 1 : 0);
            end
            if (n == 0) begin
                checks++;
                if (valid_cycles !== 0) begin errors++; $display("FAIL cnt%0d_no_valid got=%0d exp=0", t, valid_cycles); end
            end
        end
    endtask

    task automatic test_flush;
        int found;
        int stray;
        found = 0; stray = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = VEC; in_count = 4'd8; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (out_valid && out_index == 3'd4) begin found = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (found !== 1) begin errors++; $display("FAIL flush_reach_idx4 got=%0d exp=1", found); end
        out_ready = 1'b0; flush = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({out_valid, in_ready, done} !== 3'b000) begin
            errors++; $display("FAIL flush_idle got valid=%b ready=%b done=%b exp=000", out_valid, in_ready, done);
        end
        flush = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_return got=%b exp=1", in_ready); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk); #1;
            if (out_valid || done) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL flush_no_followup got=%0d exp=0", stray); end
    endtask

    task automatic test_reset_mid;
        int found;
        found = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = VEC; in_count = 4'd8; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (out_valid && out_index == 3'd2) begin found = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (found !== 1) begin errors++; $display("FAIL rstmid_reach_idx2 got=%0d exp=1", found); end
        rst = 1'b1; out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid, done, out_last, in_ready, out_index, out_a, out_b, out_c} !== 14'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got valid=%b done=%b last=%b ready=%b idx=%0d a=%b b=%b c=%b exp all 0",
                     out_valid, done, out_last, in_ready, out_index, out_a, out_b, out_c);
        end
        @(negedge clk);
        rst = 1'b0;
        run_word(VEC, 4'd2, 100, 20);
        checks++;
        if (got_idx.size() != 2) begin errors++; $display("FAIL rstmid_nbeats got=%0d exp=2", got_idx.size()); end
        for (int i = 0; i < 2 && i < got_idx.size(); i++) begin
            checks++;
            if (got_idx[i] !== i || got_rec[i] !== model_rec(VEC, i) || got_last[i] !== (i == 1)) begin
                errors++;
                $display("FAIL rstmid_beat%0d got idx=%0d rec=%b last=%b exp idx=%0d rec=%b last=%b",
                         i, got_idx[i], got_rec[i], got_last[i], i, model_rec(VEC, i), (i == 1));
            end
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL rstmid_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [55:0] wd [2];
        logic [3:0]  wc [2];
        logic [6:0]  exp_rec [5];
        int          exp_idx [5];
        logic [6:0]  b_rec [$];
        int          b_idx [$];
        int          b_cyc [$];
        int          acc_cyc [2];
        int          sel;
        int          first_done;
        logic        done_ready;
        wd[0] = VEC; wc[0] = 4'd3;
        wd[1] = 56'({$urandom(), $urandom()}); wc[1] = 4'd2;
        for (int i = 0; i < 5; i++) begin
            exp_idx[i] = (i < 3) ? i : i - 3;
            exp_rec[i] = (i < 3) ? model_rec(wd[0], i) : model_rec(wd[1], i - 3);
        end
        sel = 0; first_done = -1; done_ready = 1'b0; acc_cyc[0] = -1; acc_cyc[1] = -1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            in_valid = (sel < 2);
            if (sel < 2) begin in_data = wd[sel]; in_count = wc[sel]; end
            out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) begin
                b_rec.push_back({out_a, out_b, out_c});
                b_idx.push_back(int'(out_index));
                b_cyc.push_back(cyc);
            end
            if (done && first_done < 0) begin first_done = cyc; done_ready = in_ready; end
            if (in_valid && in_ready) begin acc_cyc[sel] = cyc; sel++; end
        end
        in_valid = 1'b0;
        checks++;
        if (b_rec.size() != 5) begin errors++; $display("FAIL b2b_nbeats got=%0d exp=5", b_rec.size()); end
        for (int i = 0; i < 5 && i < b_rec.size(); i++) begin
            checks++;
            if (b_idx[i] !== exp_idx[i] || b_rec[i] !== exp_rec[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d got idx=%0d rec=%b exp idx=%0d rec=%b",
                         i, b_idx[i], b_rec[i], exp_idx[i], exp_rec[i]);
            end
        end
        checks++;
        if (done_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_done got=%b exp=1", done_ready); end
        checks++;
        if (first_done < 0 || acc_cyc[1] !== first_done) begin
            errors++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", acc_cyc[1], first_done);
        end
        if (b_cyc.size() >= 4) begin
            checks++;
            if (b_cyc[3] !== first_done + 1) begin
                errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", b_cyc[3], first_done + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_full();
        test_backpressure();
        test_counts();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
